// File: rtl/load_store_unit.sv
// load_store_unit
//   Sits between the execute stage and the data bus. Accepts one memory
//   request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), checks alignment and funct3,
//   issues a single-cycle read or write strobe, waits for the bus to go idle,
//   and returns sign/zero-extended load data with misaligned/error flags.
//   Misaligned or illegal requests complete locally without touching the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a request that spends
//   TIMEOUT_CYCLES cycles in ISSUE+WAIT (responds with resp_error = 1).
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   req_*              request handshake (valid/ready) and payload
//   resp_*             one-cycle completion pulse with data and status flags
//   bus_rd / bus_wd    single-cycle read / write strobes
//   bus_size_*         00 byte, 01 half, 10 word (_in write, _out read)
//   bus_addr_*         byte address (_in write, _out read)
//   bus_data_in        store data toward the bus
//   bus_data_out       load data from the bus
//   bus_ready/bus_busy bus flow control
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_error,
    output logic        bus_rd,
    output logic        bus_wd,
    output logic [1:0]  bus_size_in,
    output logic [1:0]  bus_size_out,
    output logic [31:0] bus_addr_in,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_data_in,
    input  logic [31:0] bus_data_out,
    input  logic        bus_ready,
    input  logic        bus_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nxt;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic        mis_q;
    logic        err_q;

    logic        req_ill;
    logic        req_mis;
    logic        bus_go;
    logic        active;
    logic        timeout;

    function automatic logic illegal_funct3(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] || (f3[1:0] == 2'b11);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Size comes from funct3[1:0] for both loads and stores (LBU/LHU share it).
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'b0, d[7:0]};
            3'b101:  return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {24'b0, d[7:0]};
            2'b01:   return {16'b0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Misalignment is only meaningful for a legal funct3; illegal codes
    // report resp_error alone.
    assign req_ill = illegal_funct3(req_we, req_funct3);
    assign req_mis = !req_ill && misaligned(req_funct3, req_addr[1:0]);
    assign bus_go  = bus_ready && !bus_busy;
    assign active  = (state == ISSUE) || (state == WAIT);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Held at zero in IDLE so it starts from zero on entry to ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state == IDLE)
            wait_cnt <= '0;
        else if (active)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires during the TIMEOUT_CYCLES-th cycle spent in ISSUE+WAIT.
    assign timeout = active && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_nxt = (req_ill || req_mis) ? RESP : ISSUE;
            end
            ISSUE: begin
                if (timeout)
                    state_nxt = RESP;
                else if (bus_go)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (timeout || !bus_busy)
                    state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            result_q <= 32'b0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        result_q <= 32'b0;
                        mis_q    <= req_mis;
                        err_q    <= req_ill;
                    end
                end
                ISSUE, WAIT: begin
                    // A timed-out request reports zero data even if the bus
                    // happened to finish in the same cycle.
                    if (timeout) begin
                        err_q    <= 1'b1;
                        result_q <= 32'b0;
                    end else if (state == WAIT && !bus_busy) begin
                        result_q <= we_q ? 32'b0 : load_extend(funct3_q, bus_data_out);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESP);
    assign resp_rdata      = (state == RESP) ? result_q : 32'b0;
    assign resp_misaligned = (state == RESP) && mis_q;
    assign resp_error      = (state == RESP) && err_q;

    // Strobes are combinational so they last exactly the one ISSUE cycle in
    // which the bus accepts.
    assign bus_rd       = (state == ISSUE) && bus_go && !we_q;
    assign bus_wd       = (state == ISSUE) && bus_go && we_q;
    assign bus_size_out = (active && !we_q) ? funct3_q[1:0] : 2'b00;
    assign bus_addr_out = (active && !we_q) ? addr_q : 32'b0;
    assign bus_size_in  = (active && we_q) ? funct3_q[1:0] : 2'b00;
    assign bus_addr_in  = (active && we_q) ? addr_q : 32'b0;
    assign bus_data_in  = (active && we_q) ? store_data(funct3_q[1:0], wdata_q) : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_error;
    logic [31:0] resp_rdata;
    logic        bus_rd, bus_wd;
    logic [1:0]  bus_size_in, bus_size_out;
    logic [31:0] bus_addr_in, bus_addr_out, bus_data_in, bus_data_out;
    logic        bus_ready, bus_busy;

    logic [137:0] outs;
    assign outs = {req_ready, resp_valid, resp_rdata, resp_misaligned, resp_error,
                   bus_rd, bus_wd, bus_size_in, bus_size_out,
                   bus_addr_in, bus_addr_out, bus_data_in};

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_error(resp_error),
        .bus_rd(bus_rd), .bus_wd(bus_wd),
        .bus_size_in(bus_size_in), .bus_size_out(bus_size_out),
        .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_ready(bus_ready), .bus_busy(bus_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations of the last transaction
    int          o_rd, o_wd, o_strobe_k, o_resp_k, o_resp_cnt, o_acc_ready, o_busy_ready;
    logic [31:0] o_rdata, o_addr, o_data;
    logic [1:0]  o_size;
    logic        o_mis, o_err;

    // Reference model results
    int          e_rd, e_wd, e_strobe_k, e_resp_k;
    logic [31:0] e_rdata, e_addr, e_data;
    logic [1:0]  e_size;
    logic        e_mis, e_err;

    // Behavioural model: decode the mnemonic into a byte count and signedness,
    // then derive every expected value with plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] bdata,
                         input int rl, input int bl);
        int     nbytes;
        bit     legal, sgn;
        longint v, span;
        legal = 1; sgn = 0; nbytes = 0;
        if (we) begin
            case (f3)
                3'd0: nbytes = 1;
                3'd1: nbytes = 2;
                3'd2: nbytes = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f3)
                3'd0: begin nbytes = 1; sgn = 1; end
                3'd1: begin nbytes = 2; sgn = 1; end
                3'd2: nbytes = 4;
                3'd4: nbytes = 1;
                3'd5: nbytes = 2;
                default: legal = 0;
            endcase
        end
        e_err = !legal;
        e_mis = 0;
        if (legal) e_mis = (addr % nbytes) != 0;
        e_rd = 0; e_wd = 0; e_strobe_k = -1;
        e_rdata = 0; e_addr = 0; e_data = 0; e_size = 0;
        if (!legal || e_mis) begin
            e_resp_k = 1;
        end else begin
            span   = longint'(1) << (8 * nbytes);
            e_size = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
            e_addr = addr;
            v      = longint'(wdata) % span;
            e_data = v[31:0];
            if (!we) begin
                v = longint'(bdata) % span;
                if (sgn && v >= span / 2) v = v - span;
                e_rdata = v[31:0];
            end
            e_strobe_k = 1 + rl;
            e_resp_k   = 3 + rl + bl;
            if (we) e_wd = 1; else e_rd = 1;
`ifdef LSU_TIMEOUT_EN
            if (rl + bl + 2 >= TO) begin
                e_resp_k = TO + 1;
                e_err    = 1;
                e_rdata  = 0;
                if (e_strobe_k > TO) begin
                    e_strobe_k = -1; e_rd = 0; e_wd = 0;
                end
            end
`endif
        end
    endtask

    // Drives one request plus a bus that withholds bus_ready for rl ISSUE
    // cycles and holds bus_busy for bl WAIT cycles; records what it sees.
    // Starts and ends just after a rising edge with the unit in IDLE.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] bdata,
                           input int rl, input int bl, input bit hold);
        int s;
        s = 1 + rl;
        o_rd = 0; o_wd = 0; o_strobe_k = -1; o_resp_k = -1; o_resp_cnt = 0;
        o_acc_ready = 0; o_busy_ready = 0;
        o_rdata = 0; o_addr = 0; o_data = 0; o_size = 0; o_mis = 0; o_err = 0;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        bus_ready = $urandom; bus_busy = 0; bus_data_out = $urandom;
        @(negedge clk);
        o_acc_ready = req_ready;
        @(posedge clk); #1;
        if (hold) begin
            req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
        end else begin
            req_valid = 0;
        end
        for (int k = 1; k <= 60 && o_resp_cnt == 0; k++) begin
            bus_ready    = (k >= s);
            bus_busy     = (k > s) && (k <= s + bl);
            bus_data_out = (k == s + 1 + bl) ? bdata : $urandom;
            @(negedge clk);
            if (req_ready) o_busy_ready++;
            if (bus_rd) begin
                o_rd++; o_strobe_k = k; o_addr = bus_addr_out; o_size = bus_size_out;
            end
            if (bus_wd) begin
                o_wd++; o_strobe_k = k; o_addr = bus_addr_in; o_size = bus_size_in;
                o_data = bus_data_in;
            end
            if (resp_valid) begin
                o_resp_cnt++; o_resp_k = k; o_rdata = resp_rdata;
                o_mis = resp_misaligned; o_err = resp_error;
            end
            @(posedge clk); #1;
        end
        bus_ready = 0; bus_busy = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 32'h100; req_wdata = 32'hFFFF_FFFF;
        bus_ready = 1; bus_busy = 0; bus_data_out = 32'hFFFF_FFFF;
        #3;
        n_checks++;
        if (outs !== {1'b1, 137'd0}) $display("FAIL reset_outputs: got %h expected %h", outs, {1'b1, 137'd0});
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (outs !== {1'b1, 137'd0}) $display("FAIL reset_held: got %h expected %h", outs, {1'b1, 137'd0});
        else n_pass++;
        req_valid = 0; bus_ready = 0;
        rst = 1;
    endtask

    task automatic test_directed();
        // LW aligned
        run_txn(1'b0, 3'd2, 32'h10, 32'h0, 32'h8765_4321, 0, 0, 1'b0);
        n_checks++; if (o_rd !== 1) $display("FAIL lw_rd_pulses: got %0d expected 1", o_rd); else n_pass++;
        n_checks++; if (o_size !== 2'b10) $display("FAIL lw_size: got %b expected 10", o_size); else n_pass++;
        n_checks++; if (o_addr !== 32'h10) $display("FAIL lw_addr: got %h expected 00000010", o_addr); else n_pass++;
        n_checks++; if (o_resp_k !== 3) $display("FAIL lw_latency: got %0d expected 3", o_resp_k); else n_pass++;
        n_checks++; if (o_rdata !== 32'h8765_4321) $display("FAIL lw_rdata: got %h expected 87654321", o_rdata); else n_pass++;
        n_checks++; if ({o_mis, o_err} !== 2'b00) $display("FAIL lw_flags: got %b expected 00", {o_mis, o_err}); else n_pass++;
        // LB / LBU sign versus zero extension
        run_txn(1'b0, 3'd0, 32'h11, 32'h0, 32'h0000_0080, 0, 0, 1'b0);
        n_checks++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata); else n_pass++;
        run_txn(1'b0, 3'd4, 32'h11, 32'h0, 32'h0000_0080, 0, 0, 1'b0);
        n_checks++; if (o_rdata !== 32'h0000_0080) $display("FAIL lbu_rdata: got %h expected 00000080", o_rdata); else n_pass++;
        // SH aligned
        run_txn(1'b1, 3'd1, 32'h22, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        n_checks++; if (o_wd !== 1 || o_rd !== 0) $display("FAIL sh_strobes: got wd=%0d rd=%0d expected wd=1 rd=0", o_wd, o_rd); else n_pass++;
        n_checks++; if (o_size !== 2'b01) $display("FAIL sh_size: got %b expected 01", o_size); else n_pass++;
        n_checks++; if (o_addr !== 32'h22) $display("FAIL sh_addr: got %h expected 00000022", o_addr); else n_pass++;
        n_checks++; if (o_data !== 32'h0000_BEEF) $display("FAIL sh_data: got %h expected 0000beef", o_data); else n_pass++;
        n_checks++; if (o_rdata !== 32'h0) $display("FAIL sh_rdata: got %h expected 00000000", o_rdata); else n_pass++;
        // Misaligned LW and SH
        run_txn(1'b0, 3'd2, 32'h13, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
        n_checks++; if (o_rd !== 0) $display("FAIL lw_mis_strobe: got %0d expected 0", o_rd); else n_pass++;
        n_checks++; if (o_resp_k !== 1) $display("FAIL lw_mis_latency: got %0d expected 1", o_resp_k); else n_pass++;
        n_checks++; if ({o_mis, o_err, o_rdata} !== {2'b10, 32'h0}) $display("FAIL lw_mis_resp: got mis=%b err=%b data=%h expected mis=1 err=0 data=0", o_mis, o_err, o_rdata); else n_pass++;
        run_txn(1'b1, 3'd1, 32'h21, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
        n_checks++; if (o_mis !== 1'b1 || o_wd !== 0) $display("FAIL sh_mis: got mis=%b wd=%0d expected mis=1 wd=0", o_mis, o_wd); else n_pass++;
        // Illegal load funct3
        run_txn(1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 0, 0, 1'b0);
        n_checks++; if ({o_err, o_mis} !== 2'b10 || o_resp_k !== 1 || o_rd !== 0) $display("FAIL illegal_load: got err=%b mis=%b k=%0d rd=%0d expected err=1 mis=0 k=1 rd=0", o_err, o_mis, o_resp_k, o_rd); else n_pass++;
`ifndef LSU_TIMEOUT_EN
        // Three busy cycles during WAIT
        run_txn(1'b0, 3'd2, 32'h30, 32'h0, 32'hA5A5_0F0F, 0, 3, 1'b0);
        n_checks++; if (o_resp_k !== 6) $display("FAIL busy3_latency: got %0d expected 6", o_resp_k); else n_pass++;
        n_checks++; if (o_rdata !== 32'hA5A5_0F0F) $display("FAIL busy3_rdata: got %h expected a5a50f0f", o_rdata); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, bd;
        int          rl, bl;
        bit          hold;
        for (int i = 0; i < 40; i++) begin
            we = $urandom; f3 = $urandom; a = $urandom_range(0, 255);
            wd = $urandom; bd = $urandom;
            rl = $urandom_range(0, 3); bl = $urandom_range(0, 3);
            hold = (i < 39) ? 1'($urandom) : 1'b0;
            model(we, f3, a, wd, bd, rl, bl);
            run_txn(we, f3, a, wd, bd, rl, bl, hold);
            n_checks++; if (o_resp_cnt !== 1) $display("FAIL rnd%0d_resp_count: got %0d expected 1", i, o_resp_cnt); else n_pass++;
            n_checks++; if (o_resp_k !== e_resp_k) $display("FAIL rnd%0d_latency: got %0d expected %0d", i, o_resp_k, e_resp_k); else n_pass++;
            n_checks++; if (o_rdata !== e_rdata) $display("FAIL rnd%0d_rdata: got %h expected %h", i, o_rdata, e_rdata); else n_pass++;
            n_checks++; if ({o_mis, o_err} !== {e_mis, e_err}) $display("FAIL rnd%0d_flags: got %b expected %b", i, {o_mis, o_err}, {e_mis, e_err}); else n_pass++;
            n_checks++; if (o_rd !== e_rd || o_wd !== e_wd) $display("FAIL rnd%0d_strobes: got rd=%0d wd=%0d expected rd=%0d wd=%0d", i, o_rd, o_wd, e_rd, e_wd); else n_pass++;
            n_checks++; if (o_acc_ready !== 1 || o_busy_ready !== 0) $display("FAIL rnd%0d_req_ready: got idle=%0d busy_cycles=%0d expected 1 and 0", i, o_acc_ready, o_busy_ready); else n_pass++;
            if (e_strobe_k >= 0) begin
                n_checks++; if (o_strobe_k !== e_strobe_k) $display("FAIL rnd%0d_strobe_cycle: got %0d expected %0d", i, o_strobe_k, e_strobe_k); else n_pass++;
                n_checks++; if (o_addr !== e_addr || o_size !== e_size) $display("FAIL rnd%0d_addr_size: got %h/%b expected %h/%b", i, o_addr, o_size, e_addr, e_size); else n_pass++;
                if (we) begin
                    n_checks++; if (o_data !== e_data) $display("FAIL rnd%0d_wdata: got %h expected %h", i, o_data, e_data); else n_pass++;
                end
            end
        end
        req_valid = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, bd;
        for (int i = 0; i < 6; i++) begin
            a = {$urandom_range(0, 63), 2'b00};
            bd = $urandom;
            run_txn(1'b0, 3'd2, a, 32'h0, bd, 0, 0, 1'b1);
            n_checks++; if (o_acc_ready !== 1 || o_resp_k !== 3) $display("FAIL b2b%0d_spacing: got ready=%0d k=%0d expected ready=1 k=3", i, o_acc_ready, o_resp_k); else n_pass++;
            n_checks++; if (o_rdata !== bd) $display("FAIL b2b%0d_rdata: got %h expected %h", i, o_rdata, bd); else n_pass++;
        end
        req_valid = 0;
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h40;
        bus_ready = 1; bus_busy = 0;
        @(posedge clk); #1; req_valid = 0;
        @(posedge clk); #1; bus_busy = 1;
        #2; rst = 0; #1;
        n_checks++;
        if (outs !== {1'b1, 137'd0}) $display("FAIL midreset_outputs: got %h expected %h", outs, {1'b1, 137'd0});
        else n_pass++;
        @(posedge clk); @(posedge clk); #2;
        rst = 1; bus_busy = 0; bus_ready = 1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid || bus_rd || bus_wd || !req_ready) seen++;
        end
        @(posedge clk); #1;
        n_checks++; if (seen !== 0) $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); else n_pass++;
        run_txn(1'b0, 3'd2, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0);
        n_checks++; if (o_resp_k !== 3 || o_rdata !== 32'h0BAD_F00D) $display("FAIL midreset_after: got k=%0d data=%h expected k=3 data=0badf00d", o_resp_k, o_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
        // Bus never accepts: abort after TO cycles in ISSUE
        run_txn(1'b0, 3'd2, 32'h50, 32'h0, 32'h1111_1111, 50, 0, 1'b0);
        n_checks++; if (o_resp_k !== TO + 1 || o_err !== 1'b1) $display("FAIL timeout_issue: got k=%0d err=%b expected k=%0d err=1", o_resp_k, o_err, TO + 1); else n_pass++;
        n_checks++; if (o_rdata !== 32'h0 || o_rd !== 0) $display("FAIL timeout_issue_data: got %h rd=%0d expected 0 rd=0", o_rdata, o_rd); else n_pass++;
        // Strobe issued, then bus stays busy
        run_txn(1'b0, 3'd2, 32'h54, 32'h0, 32'h2222_2222, 0, 10, 1'b0);
        n_checks++; if (o_resp_k !== TO + 1 || o_err !== 1'b1 || o_rd !== 1) $display("FAIL timeout_wait: got k=%0d err=%b rd=%0d expected k=%0d err=1 rd=1", o_resp_k, o_err, o_rd, TO + 1); else n_pass++;
`else
        // Without the timeout the unit waits as long as the bus stays busy
        run_txn(1'b0, 3'd2, 32'h50, 32'h0, 32'h3333_4444, 0, 20, 1'b0);
        n_checks++; if (o_resp_k !== 23 || o_err !== 1'b0) $display("FAIL long_wait: got k=%0d err=%b expected k=23 err=0", o_resp_k, o_err); else n_pass++;
        n_checks++; if (o_rdata !== 32'h3333_4444) $display("FAIL long_wait_rdata: got %h expected 33334444", o_rdata); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
